uart_tx: RTL and testbench

//   Serial transmitter for the single-wire async byte link; counterpart of the receive path.

---
 rtl/uart_tx.sv | 174 +++++++++++++++++
 tb/tb_uart_tx.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Byte-queued asynchronous serial transmitter: start bit, 8 data bits LSB first, STOP_BITS stop bits.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       miso,
  output logic       busy,
  output logic       done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shift;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          stop_end;
  logic          bit_tick;
  logic [7:0]    fifo_head;

  // FIFO status comes from the pointers alone so din_ready never depends on din_valid
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign din_ready = !full;
  assign push      = din_valid && !full;
  assign fifo_head = mem[rd_ptr[AW-1:0]];

  assign stop_end  = (state == S_STOP) && (cnt == '0) && (stop_idx == STOP_LAST);
  assign pop       = !empty && ((state == S_IDLE) || stop_end);
  assign bit_tick  = ((state == S_START) || (state == S_DATA)) && (cnt == '0);
  assign busy      = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (pop)           shift <= fifo_head;
    else if (bit_tick) shift <= {1'b0, shift[7:1]};
  end

`ifdef UART_TX_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (pop) par <= ^fifo_head;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      miso     <= 1'b1;
      done     <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            miso  <= 1'b0;
            cnt   <= BIT_RELOAD;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            miso    <= shift[0];
            bit_idx <= '0;
            cnt     <= BIT_RELOAD;
            state   <= S_DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            cnt <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              miso  <= par;
              state <= S_PARITY;
`else
              miso     <= 1'b1;
              stop_idx <= 1'b0;
              state    <= S_STOP;
`endif
            end else begin
              miso    <= shift[0];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (cnt == '0) begin
            miso     <= 1'b1;
            cnt      <= BIT_RELOAD;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt == '0) begin
            if (stop_idx == STOP_LAST) begin
              done <= 1'b1;
              // Back-to-back: next start bit follows the last stop clock directly
              if (pop) begin
                miso  <= 1'b0;
                cnt   <= BIT_RELOAD;
                state <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
              cnt      <= BIT_RELOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: queue-and-frame reference model driven by randomized stimulus.
module tb_uart_tx;

  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic [7:0] din4 = '0;
  logic       din_valid = 1'b0;
  logic       din_valid4 = 1'b0;
  logic       din_ready, miso, busy, done;
  logic       din_ready4, miso4, busy4, done4;

  uart_tx dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .miso(miso), .busy(busy), .done(done)
  );

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(din_valid4),
    .din_ready(din_ready4), .miso(miso4), .busy(busy4), .done(done4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: byte queue plus the edge at which the current frame started
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_start = 0;
  int         m_t = 0;
  logic [7:0] m_byte = '0;
  logic [3:0] got;
  logic [3:0] exp_v;

  function automatic int frame_len(input int which);
    return (9 + PAR + ((which != 0) ? 2 : 1)) * ((which != 0) ? 4 : 1);
  endfunction

  function automatic logic exp_bit(input logic [7:0] b, input int off, input int cpb);
    int pos = off / cpb;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (PAR == 1 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  // Advance one clock, update the model, and capture {miso,done,busy,din_ready} actual/expected
  task automatic step(input int which, output bit acc);
    int         cpb;
    int         flen;
    logic [7:0] d;
    logic       v;
    bit         pre_ready;
    bit         done_e;
    logic       e_miso;
    cpb = (which != 0) ? 4 : 1;
    flen = frame_len(which);
    d = (which != 0) ? din4 : din;
    v = (which != 0) ? din_valid4 : din_valid;
    pre_ready = (m_q.size() < DEPTH);
    acc = 1'b0;
    done_e = 1'b0;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
    end else begin
      if (m_active && m_t == m_start + flen) begin
        done_e = 1'b1;
        m_active = 1'b0;
      end
      if (!m_active && m_q.size() != 0) begin
        m_byte = m_q.pop_front();
        m_active = 1'b1;
        m_start = m_t;
      end
      if (v && pre_ready) begin
        m_q.push_back(d);
        acc = 1'b1;
      end
    end
    e_miso = m_active ? exp_bit(m_byte, m_t - m_start, cpb) : 1'b1;
    exp_v = {e_miso, done_e, (m_active || m_q.size() != 0), (m_q.size() < DEPTH)};
    #1;
    got = (which != 0) ? {miso4, done4, busy4, din_ready4} : {miso, done, busy, din_ready};
    m_t++;
  endtask

  task automatic drain(input int which, input string name);
    bit acc;
    int k = 0;
    while ((m_active || m_q.size() != 0) && k < 1000) begin
      din = 8'($urandom);
      din4 = 8'($urandom);
      step(which, acc);
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL %s drain t=%0d miso/done/busy/ready got %b expected %b", name, m_t, got, exp_v);
      end
      n_checks++;
      k++;
    end
    if (m_active || m_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain timeout: still busy after %0d cycles, required idle", name, k);
    end
    n_checks++;
    repeat (2) begin
      step(which, acc);
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL %s idle miso/done/busy/ready got %b expected %b", name, got, exp_v);
      end
      n_checks++;
    end
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b1;
    din_valid = 1'b0;
    din_valid4 = 1'b0;
    repeat (2) begin
      step(0, acc);
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset miso/done/busy/ready got %b expected %b", got, exp_v);
      end
      n_checks++;
    end
    if ({miso4, done4, busy4, din_ready4} !== 4'b1001) begin
      n_fail++;
      $display("FAIL reset_dut4 miso/done/busy/ready got %b expected 1001", {miso4, done4, busy4, din_ready4});
    end
    n_checks++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit         acc;
    logic [8:0] seq;
    din = 8'hA5;
    din_valid = 1'b1;
    step(0, acc);
    if (acc !== 1'b1 || got !== exp_v) begin
      n_fail++;
      $display("FAIL single accept acc=%b got %b expected %b", acc, got, exp_v);
    end
    n_checks++;
    din_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      din = 8'($urandom);
      step(0, acc);
      seq[i] = miso;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL single bit%0d miso/done/busy/ready got %b expected %b", i, got, exp_v);
      end
      n_checks++;
    end
    if (seq !== 9'b101001010) begin
      n_fail++;
      $display("FAIL single_seq start+data got %b expected %b", seq, 9'b101001010);
    end
    n_checks++;
    drain(0, "single");
  endtask

  task automatic test_burst();
    bit         acc;
    logic [7:0] b [3];
    int         first_low = -1;
    int         last_done = -1;
    int         dones = 0;
    b[0] = 8'h00; b[1] = 8'hFF; b[2] = 8'h3C;
    for (int k = 0; k < 200 && (k < 3 || m_active || m_q.size() != 0); k++) begin
      if (k < 3) begin
        din = b[k];
        din_valid = 1'b1;
      end else begin
        din = 8'($urandom);
        din_valid = 1'b0;
      end
      step(0, acc);
      if (got !== exp_v || (k < 3 && acc !== 1'b1)) begin
        n_fail++;
        $display("FAIL burst t=%0d acc=%b got %b expected %b", k, acc, got, exp_v);
      end
      n_checks++;
      if (miso === 1'b0 && first_low < 0) first_low = k;
      if (done === 1'b1) begin
        dones++;
        last_done = k;
      end
    end
    if (dones != 3) begin
      n_fail++;
      $display("FAIL burst_done_count got %0d expected 3", dones);
    end
    n_checks++;
    if (last_done - first_low != 3 * frame_len(0)) begin
      n_fail++;
      $display("FAIL burst_span got %0d expected %0d", last_done - first_low, 3 * frame_len(0));
    end
    n_checks++;
    drain(0, "burst");
  endtask

  task automatic test_fill();
    bit         acc;
    int         idx = 0;
    bit         saw_low = 1'b0;
    logic [7:0] fb [6];
    for (int i = 0; i < 6; i++) fb[i] = 8'($urandom);
    for (int k = 0; k < 400 && (idx < 6 || m_active || m_q.size() != 0); k++) begin
      if (idx < 6) begin
        din = fb[idx];
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      step(0, acc);
      if (acc) idx++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL fill t=%0d miso/done/busy/ready got %b expected %b", k, got, exp_v);
      end
      n_checks++;
      if (din_ready === 1'b0) saw_low = 1'b1;
    end
    din_valid = 1'b0;
    if (saw_low !== 1'b1 || idx != 6) begin
      n_fail++;
      $display("FAIL fill_backpressure saw_ready_low=%b accepted=%0d expected 1 and 6", saw_low, idx);
    end
    n_checks++;
    drain(0, "fill");
  endtask

  task automatic test_clks4();
    bit acc;
    int done_at = -1;
    din4 = 8'h81;
    din_valid4 = 1'b1;
    step(1, acc);
    din_valid4 = 1'b0;
    if (acc !== 1'b1 || got !== exp_v) begin
      n_fail++;
      $display("FAIL clks4 accept acc=%b got %b expected %b", acc, got, exp_v);
    end
    n_checks++;
    for (int k = 0; k < 200 && (m_active || m_q.size() != 0); k++) begin
      din4 = 8'($urandom);
      step(1, acc);
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL clks4 t=%0d miso/done/busy/ready got %b expected %b", k, got, exp_v);
      end
      n_checks++;
      if (done4 === 1'b1 && done_at < 0) done_at = k;
    end
    if (done_at != frame_len(1)) begin
      n_fail++;
      $display("FAIL clks4_frame_len got %0d expected %0d", done_at, frame_len(1));
    end
    n_checks++;
    drain(1, "clks4");
  endtask

  task automatic test_reset_mid();
    bit acc;
    int k = 0;
    int dones = 0;
    int lows = 0;
    for (int i = 0; i < 3; i++) begin
      din = 8'($urandom);
      din_valid = 1'b1;
      step(0, acc);
      if (got !== exp_v || acc !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid push%0d acc=%b got %b expected %b", i, acc, got, exp_v);
      end
      n_checks++;
    end
    din_valid = 1'b0;
    while (!(m_active && (m_t - 1 - m_start) == 4) && k < 50) begin
      step(0, acc);
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid run got %b expected %b", got, exp_v);
      end
      n_checks++;
      k++;
    end
    rst = 1'b1;
    din = 8'($urandom);
    din_valid = 1'b1;
    step(0, acc);
    if (got !== exp_v || got !== 4'b1001) begin
      n_fail++;
      $display("FAIL rstmid reset miso/done/busy/ready got %b expected %b", got, exp_v);
    end
    n_checks++;
    rst = 1'b0;
    din_valid = 1'b0;
    repeat (30) begin
      step(0, acc);
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid after got %b expected %b", got, exp_v);
      end
      n_checks++;
      if (done === 1'b1) dones++;
      if (miso === 1'b0) lows++;
    end
    if (dones != 0 || lows != 0) begin
      n_fail++;
      $display("FAIL rstmid_discard done_pulses=%0d low_bits=%0d expected 0 and 0", dones, lows);
    end
    n_checks++;
  endtask

  task automatic test_random();
    bit acc;
    int n;
    int idx;
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 7);
      idx = 0;
      for (int k = 0; k < 300 && idx < n; k++) begin
        din = 8'($urandom);
        din_valid = ($urandom_range(0, 3) != 0);
        step(0, acc);
        if (acc) idx++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL random it=%0d miso/done/busy/ready got %b expected %b", it, got, exp_v);
        end
        n_checks++;
      end
      din_valid = 1'b0;
      repeat ($urandom_range(0, 12)) begin
        din = 8'($urandom);
        step(0, acc);
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL random gap it=%0d got %b expected %b", it, got, exp_v);
        end
        n_checks++;
      end
    end
    drain(0, "random");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] b, input logic e);
    bit acc;
    bit found = 1'b0;
    din = b;
    din_valid = 1'b1;
    step(0, acc);
    din_valid = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step(0, acc);
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL parity t=%0d got %b expected %b", k, got, exp_v);
      end
      n_checks++;
      if (m_active && (m_t - 1 - m_start) == 9) begin
        found = 1'b1;
        if (miso !== e) begin
          n_fail++;
          $display("FAIL parity_bit byte %h got %b expected %b", b, miso, e);
        end
        n_checks++;
      end
    end
    if (!found) begin
      n_fail++;
      $display("FAIL parity_bit byte %h never reached parity slot", b);
      n_checks++;
    end
    drain(0, "parity");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fill();
    test_clks4();
    test_reset_mid();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'hA5, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
